// File: rtl/descrambler_lock_ctrl.sv
// Frame-lock controller for the 30b/32b self-synchronising descrambler: hunt, slip, confirm, flush, locked.
// Optional DESCR_LOCK_STATS_EN adds saturating slip/unlock statistics counters.
module descrambler_lock_ctrl #(
  parameter int LOCK_GOOD  = 32,
  parameter int UNLOCK_BAD = 16,
  parameter int UNLOCK_WIN = 64,
  parameter int SLIP_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid_i,
  input  logic [1:0]  header_i,
`ifdef DESCR_LOCK_STATS_EN
  input  logic        stats_clr_i,
  output logic [15:0] slip_cnt_o,
  output logic [15:0] unlock_cnt_o,
`endif
  output logic        descr_en_o,
  output logic        bitslip_o,
  output logic        locked_o,
  output logic        payload_valid_o,
  output logic        lock_lost_o
);

  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam int WW = $clog2(UNLOCK_WIN + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] SLIP    = 3'd1;
  localparam logic [2:0] CONFIRM = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] LOCKED  = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [GW-1:0] good_reg, good_next, good_inc;
  logic [BW-1:0] bad_reg, bad_next, bad_inc;
  logic [WW-1:0] win_reg, win_next, win_inc;
  logic [SW-1:0] wait_reg, wait_next, wait_inc;
  logic          hdr_good;
  logic          descr_en_reg, bitslip_reg, locked_reg, payload_valid_reg, lock_lost_reg;

  assign hdr_good = (header_i == 2'b01) || (header_i == 2'b10);

  // Saturating increments; the FSM normally leaves before any limit is exceeded
  assign good_inc = (good_reg == GW'(LOCK_GOOD))  ? good_reg : good_reg + 1'b1;
  assign win_inc  = (win_reg  == WW'(UNLOCK_WIN)) ? win_reg  : win_reg  + 1'b1;
  assign wait_inc = (wait_reg == SW'(SLIP_WAIT))  ? wait_reg : wait_reg + 1'b1;
  assign bad_inc  = (hdr_good || bad_reg == BW'(UNLOCK_BAD)) ? bad_reg : bad_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    bad_next   = bad_reg;
    win_next   = win_reg;
    wait_next  = wait_reg;
    if (frame_valid_i) begin
      case (state_reg)
        HUNT: begin
          if (hdr_good) begin
            state_next = CONFIRM;
            good_next  = GW'(1);
          end else begin
            state_next = SLIP;
            wait_next  = '0;
          end
        end
        // Frames arriving while the gearbox settles are counted but their headers ignored
        SLIP: begin
          if (wait_inc == SW'(SLIP_WAIT)) begin
            state_next = HUNT;
            wait_next  = '0;
          end else begin
            wait_next = wait_inc;
          end
        end
        CONFIRM: begin
          if (!hdr_good) begin
            state_next = SLIP;
            good_next  = '0;
            wait_next  = '0;
          end else if (good_inc == GW'(LOCK_GOOD)) begin
            state_next = FLUSH;
            good_next  = '0;
          end else begin
            good_next = good_inc;
          end
        end
        FLUSH: begin
          state_next = LOCKED;
          win_next   = '0;
          bad_next   = '0;
        end
        LOCKED: begin
          // Bad-header threshold takes priority over the window wrap
          if (bad_inc == BW'(UNLOCK_BAD)) begin
            state_next = HUNT;
            win_next   = '0;
            bad_next   = '0;
            good_next  = '0;
          end else if (win_inc == WW'(UNLOCK_WIN)) begin
            win_next = '0;
            bad_next = '0;
          end else begin
            win_next = win_inc;
            bad_next = bad_inc;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= HUNT;
      good_reg          <= '0;
      bad_reg           <= '0;
      win_reg           <= '0;
      wait_reg          <= '0;
      descr_en_reg      <= 1'b0;
      bitslip_reg       <= 1'b0;
      locked_reg        <= 1'b0;
      payload_valid_reg <= 1'b0;
      lock_lost_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      good_reg          <= good_next;
      bad_reg           <= bad_next;
      win_reg           <= win_next;
      wait_reg          <= wait_next;
      descr_en_reg      <= (state_next == FLUSH) || (state_next == LOCKED);
      bitslip_reg       <= (state_next == SLIP) && (state_reg != SLIP);
      locked_reg        <= (state_next == LOCKED);
      payload_valid_reg <= (state_reg == LOCKED) && (state_next == LOCKED) && frame_valid_i;
      lock_lost_reg     <= (state_reg == LOCKED) && (state_next == HUNT);
    end
  end

  assign descr_en_o      = descr_en_reg;
  assign bitslip_o       = bitslip_reg;
  assign locked_o        = locked_reg;
  assign payload_valid_o = payload_valid_reg;
  assign lock_lost_o     = lock_lost_reg;

`ifdef DESCR_LOCK_STATS_EN
  logic [15:0] slip_cnt_reg, unlock_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_cnt_reg   <= '0;
      unlock_cnt_reg <= '0;
    end else if (stats_clr_i) begin
      slip_cnt_reg   <= '0;
      unlock_cnt_reg <= '0;
    end else begin
      if ((state_next == SLIP) && (state_reg != SLIP) && (slip_cnt_reg != 16'hFFFF))
        slip_cnt_reg <= slip_cnt_reg + 16'd1;
      if ((state_reg == LOCKED) && (state_next == HUNT) && (unlock_cnt_reg != 16'hFFFF))
        unlock_cnt_reg <= unlock_cnt_reg + 16'd1;
    end
  end

  assign slip_cnt_o   = slip_cnt_reg;
  assign unlock_cnt_o = unlock_cnt_reg;
`endif

endmodule

// File: tb/tb_descrambler_lock_ctrl.sv
// Directed testbench for descrambler_lock_ctrl: lock acquisition, slips, unlock windows, gaps, async reset.
module tb_descrambler_lock_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_valid_i = 1'b0;
  logic [1:0] header_i = 2'b00;
  logic       descr_en_o, bitslip_o, locked_o, payload_valid_o, lock_lost_o;
`ifdef DESCR_LOCK_STATS_EN
  logic        stats_clr_i = 1'b0;
  logic [15:0] slip_cnt_o, unlock_cnt_o;
`endif

  int checks = 0;
  int failures = 0;
  int slips_seen = 0;
  int losses_seen = 0;

  descrambler_lock_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_valid_i   (frame_valid_i),
    .header_i        (header_i),
`ifdef DESCR_LOCK_STATS_EN
    .stats_clr_i     (stats_clr_i),
    .slip_cnt_o      (slip_cnt_o),
    .unlock_cnt_o    (unlock_cnt_o),
`endif
    .descr_en_o      (descr_en_o),
    .bitslip_o       (bitslip_o),
    .locked_o        (locked_o),
    .payload_valid_o (payload_valid_o),
    .lock_lost_o     (lock_lost_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One frame slot: drive inputs, take the edge, sample 1ns later
  task automatic step(input logic v, input logic [1:0] h);
    frame_valid_i = v;
    header_i = h;
    @(posedge clk);
    #1;
    if (bitslip_o) slips_seen++;
    if (lock_lost_o) losses_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_valid_i = 1'b0;
    header_i = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slips_seen = 0;
    losses_seen = 0;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 33; i++) step(1'b1, 2'b01);
  endtask

  initial begin
    #12;
    check_eq("rst_descr_en", descr_en_o, 0);
    check_eq("rst_bitslip", bitslip_o, 0);
    check_eq("rst_locked", locked_o, 0);
    check_eq("rst_payload_valid", payload_valid_o, 0);
    check_eq("rst_lock_lost", lock_lost_o, 0);
    rst_n = 1'b1;

    // Continuous good headers: FLUSH after 32, LOCKED after 33, payload after 34
    for (int i = 1; i <= 34; i++) begin
      step(1'b1, 2'b01);
      if (i == 31) check_eq("t1_f31_descr_en", descr_en_o, 0);
      if (i == 32) begin
        check_eq("t1_f32_descr_en", descr_en_o, 1);
        check_eq("t1_f32_locked", locked_o, 0);
      end
      if (i == 33) begin
        check_eq("t1_f33_locked", locked_o, 1);
        check_eq("t1_f33_payload_valid", payload_valid_o, 0);
      end
      if (i == 34) check_eq("t1_f34_payload_valid", payload_valid_o, 1);
    end

    // Gaps while locked, then asynchronous reset between edges
    step(1'b0, 2'b01);
    check_eq("t5_gap_payload_valid", payload_valid_o, 0);
    check_eq("t5_gap_locked", locked_o, 1);
    step(1'b1, 2'b01);
    check_eq("t5_valid_payload_valid", payload_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_locked", locked_o, 0);
    check_eq("t5_async_descr_en", descr_en_o, 0);
    check_eq("t5_async_payload_valid", payload_valid_o, 0);

    // Three slips (bad headers at frames 1, 6, 11), then recovery on 2'b10
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 2'b00);
      if (i == 1) check_eq("t2_f1_bitslip", bitslip_o, 1);
      if (i == 2) check_eq("t2_f2_bitslip", bitslip_o, 0);
    end
    for (int i = 1; i <= 33; i++) begin
      step(1'b1, 2'b10);
      if (i == 32) check_eq("t2_g32_locked", locked_o, 0);
    end
    check_eq("t2_locked", locked_o, 1);
    check_eq("t2_slip_pulses", slips_seen, 3);
`ifdef DESCR_LOCK_STATS_EN
    check_eq("t6_slip_cnt", slip_cnt_o, 3);
`endif

    // Bad header at confirm frame 20 restarts the count
    do_reset();
    for (int i = 0; i < 19; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b11);
    check_eq("t3_bad20_bitslip", bitslip_o, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01);
    for (int i = 1; i <= 33; i++) begin
      step(1'b1, 2'b01);
      if (i == 31) check_eq("t3_g31_descr_en", descr_en_o, 0);
      if (i == 32) check_eq("t3_g32_locked", locked_o, 0);
    end
    check_eq("t3_locked", locked_o, 1);
    check_eq("t3_slip_pulses", slips_seen, 1);

    // Window 1: 15 bad incl. the 64th frame, with invalid bad-header gaps; window 2: 16 bad
    do_reset();
    lock_up();
    for (int i = 0; i < 49; i++) step(1'b1, 2'b01);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
    for (int i = 0; i < 15; i++) step(1'b1, 2'b00);
    check_eq("t4_w1_locked", locked_o, 1);
    check_eq("t4_w1_lost_pulses", losses_seen, 0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 2'b11);
      if (i == 15) check_eq("t4_b15_locked", locked_o, 1);
    end
    check_eq("t4_b16_lock_lost", lock_lost_o, 1);
    check_eq("t4_b16_locked", locked_o, 0);
    check_eq("t4_b16_descr_en", descr_en_o, 0);
    check_eq("t4_b16_payload_valid", payload_valid_o, 0);
`ifdef DESCR_LOCK_STATS_EN
    check_eq("t6_unlock_cnt", unlock_cnt_o, 1);
`endif
    step(1'b0, 2'b01);
    check_eq("t4_lock_lost_one_cycle", lock_lost_o, 0);

    // 16th bad header landing on the window's last frame must unlock, not clear
    lock_up();
    for (int i = 0; i < 15; i++) step(1'b1, 2'b00);
    for (int i = 0; i < 48; i++) step(1'b1, 2'b01);
    check_eq("t4b_f63_locked", locked_o, 1);
    step(1'b1, 2'b00);
    check_eq("t4b_f64_lock_lost", lock_lost_o, 1);
    check_eq("t4b_f64_locked", locked_o, 0);

`ifdef DESCR_LOCK_STATS_EN
    stats_clr_i = 1'b1;
    step(1'b1, 2'b00);
    stats_clr_i = 1'b0;
    check_eq("t6_clr_bitslip", bitslip_o, 1);
    check_eq("t6_clr_slip_cnt", slip_cnt_o, 0);
    check_eq("t6_clr_unlock_cnt", unlock_cnt_o, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00);
    check_eq("t6_after_clr_slip_cnt", slip_cnt_o, 1);
`endif

    // Reset asserted mid-pulse truncates bitslip immediately
    do_reset();
    step(1'b1, 2'b00);
    check_eq("trunc_bitslip_high", bitslip_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("trunc_bitslip_low", bitslip_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 2'b01);
    check_eq("post_reset_bitslip", bitslip_o, 0);
    check_eq("post_reset_locked", locked_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
